// File: rtl/wb_commit_queue.sv
// wb_commit_queue
// Write-back commit stage between the MEM/WB boundary and the register file.
// The write-back value is chosen from link PC, memory read data or ALU
// result. Each result is buffered in a DEPTH-entry FIFO and retired in order
// through a valid/ready handshake with the register-file write port.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   in_valid / in_ready   upstream handshake (no pass-through when full)
//   in_read_data          memory read data
//   in_alu_result         ALU result
//   in_next_pc            PC+2, used as the link value
//   in_mem_to_reg         select memory data over the ALU result
//   in_write_link         link write; forces data = next_pc, dest = LINK_REG
//   in_write_en           instruction writes a register
//   in_write_reg_sel      destination register
//   in_halt               instruction is HALT
//   rf_ready              register file accepts the head entry
//   rf_write_en/reg/data  head entry presented to the register file
//   fwd_valid/reg/data    oldest pending write, for bypass
//   halted                sticky, set when a HALT retires
//   retired_count         saturating count of retired instructions
module wb_commit_queue #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int LINK_REG = 7,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_next_pc,
    input  logic              in_mem_to_reg,
    input  logic              in_write_link,
    input  logic              in_write_en,
    input  logic [REG_AW-1:0] in_write_reg_sel,
    input  logic              in_halt,
    input  logic              rf_ready,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);
    localparam logic [REG_AW-1:0] LINK_DST = REG_AW'(LINK_REG);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dest;
        logic              we;
        logic              halt;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  count;

    entry_t            new_entry;
    entry_t            head;
    logic              head_live;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        // Explicit wrap keeps non-power-of-two depths correct.
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Source selection happens at enqueue so the head only carries final data.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        new_entry      = '0;
        new_entry.we   = in_write_en | in_write_link;
        new_entry.halt = in_halt;
        if (in_write_link) begin
            new_entry.data = in_next_pc;
            new_entry.dest = LINK_DST;
        end else begin
            new_entry.data = in_mem_to_reg ? in_read_data : in_alu_result;
            new_entry.dest = in_write_reg_sel;
        end
    end

    assign head = mem[rd_ptr];

    // Once halted, the remaining entries are frozen and hidden from the
    // register file and bypass network.
    assign head_live = (count != '0) & ~halted;

    // Readiness depends only on registered state: a full queue stays not-ready
    // even when it is draining this cycle. Forced low while reset is asserted.
    assign in_ready = rst & (count != FULL_OCC) & ~halted;
    assign push     = in_valid & in_ready;

    // Non-writing entries retire without waiting for the register file.
    assign pop = head_live & (rf_ready | ~head.we);

    assign rf_write_en   = head_live & head.we;
    assign rf_write_reg  = head.dest;
    assign rf_write_data = head.data;
    assign fwd_valid     = head_live & head.we;
    assign fwd_reg       = head.dest;
    assign fwd_data      = head.data;

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count, so stale contents are never observed and the array can map to
    // plain registers or RAM without reset wiring.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                if (retired_count != '1) begin
                    retired_count <= retired_count + CNT_W'(1);
                end
                if (head.halt) begin
                    halted <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
